// File: rtl/mac_drain_pkg.sv
// mac_drain_pkg: shared types and helpers for the MAC drain stage.
//   state_t      - drain FSM states
//   idx_width()  - element index width, $clog2 with a floor of 1
//   sat_*()      - requantizer saturation limits for a given output width
package mac_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic longint unsigned sat_umax(input int ow);
        return (longint'(1) << ow) - 1;
    endfunction

    function automatic longint sat_smax(input int ow);
        return (longint'(1) << (ow - 1)) - 1;
    endfunction

    function automatic longint sat_smin(input int ow);
        return -(longint'(1) << (ow - 1));
    endfunction

endpackage

// File: rtl/mac_drain_requant.sv
// mac_requant: combinational requantizer, round-half-up right shift followed
// by saturation to OUT_WIDTH.
//   acc    - accumulator value (unsigned, or two's complement when
//            MAC_DRAIN_SIGNED_EN is defined)
//   shift  - right-shift amount, 0 passes acc through unrounded
//   result - saturated OUT_WIDTH element
// Build option: MAC_DRAIN_SIGNED_EN selects signed arithmetic and limits.
module mac_requant
    import mac_drain_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   result
);

    // Rounding bias 2^(s-1); one extra bit of headroom so acc + bias never wraps.
    logic [ACC_WIDTH:0] bias;

    always_comb begin
        bias = '0;
        if (shift != '0)
            bias = (ACC_WIDTH+1)'(1) << (shift - 1'b1);
    end

`ifdef MAC_DRAIN_SIGNED_EN
    localparam logic signed [ACC_WIDTH:0] SMAX = (ACC_WIDTH+1)'(sat_smax(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SMIN = (ACC_WIDTH+1)'(sat_smin(OUT_WIDTH));

    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] r;

    always_comb begin
        sum = $signed({acc[ACC_WIDTH-1], acc}) + $signed(bias);
        r   = sum >>> shift;
        if (r > SMAX)
            result = OUT_WIDTH'(SMAX);
        else if (r < SMIN)
            result = OUT_WIDTH'(SMIN);
        else
            result = r[OUT_WIDTH-1:0];
    end
`else
    localparam logic [ACC_WIDTH:0] UMAX = (ACC_WIDTH+1)'(sat_umax(OUT_WIDTH));

    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] r;

    always_comb begin
        sum = {1'b0, acc} + bias;
        r   = sum >> shift;
        if (r > UMAX)
            result = '1;
        else
            result = r[OUT_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/mac_drain.sv
// mac_drain: snapshots a row of MAC accumulators on start, pulses mac_clear
// so the MACs can begin the next tile, then streams the requantized snapshot
// out one element per valid/ready handshake.
//   clk, reset       - clock (rising edge), async active-low reset
//   start, shift     - capture request and shift amount (sampled together)
//   acc_in           - NUM_MACS packed accumulators, element i at [i*ACC_WIDTH +: ACC_WIDTH]
//   mac_clear        - one-cycle clear pulse to the MACs after capture
//   busy             - drain in progress
//   out_valid/ready  - output handshake
//   out_data         - requantized element, out_index its position,
//                      out_last marks element NUM_MACS-1
// Build option: MAC_DRAIN_SIGNED_EN (signed requantization, see mac_requant).
module mac_drain
    import mac_drain_pkg::*;
#(
    parameter int NUM_MACS    = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    localparam int IDX_W      = idx_width(NUM_MACS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_MACS*ACC_WIDTH-1:0] acc_in,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    output logic                          mac_clear,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last
);

    state_t                               state, state_nxt;
    logic [IDX_W-1:0]                     index, index_nxt;
    logic                                 clear_nxt;
    logic                                 capture;
    logic                                 last_idx;
    logic [NUM_MACS-1:0][ACC_WIDTH-1:0]   shadow;
    logic [SHIFT_WIDTH-1:0]               shift_q;
    logic [OUT_WIDTH-1:0]                 req_result;

    assign last_idx = (index == IDX_W'(NUM_MACS - 1));

    // start is only looked at in IDLE, so a start on the final-handshake
    // edge (state still STREAM) is dropped without capture or clear.
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        clear_nxt = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    index_nxt = '0;
                    clear_nxt = 1'b1;
                    capture   = 1'b1;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (last_idx) begin
                        state_nxt = IDLE;
                        index_nxt = '0;
                    end else begin
                        index_nxt = index + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            index     <= '0;
            mac_clear <= 1'b0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            mac_clear <= clear_nxt;
        end
    end

    // Snapshot holds the stream data; it is never read outside STREAM, so
    // it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow  <= acc_in;
            shift_q <= shift;
        end
    end

    mac_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_requant (
        .acc   (shadow[index]),
        .shift (shift_q),
        .result(req_result)
    );

    assign busy      = (state == STREAM);
    assign out_valid = busy;
    assign out_index = index;
    assign out_last  = busy && last_idx;
    // Forced to zero outside STREAM so the uninitialised snapshot never shows.
    assign out_data  = busy ? req_result : '0;

endmodule

// File: tb/tb_mac_drain.sv
module tb_mac_drain;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] acc_in;
    logic [4:0]   shift;
    logic         mac_clear;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [1:0]   out_index;
    logic         out_last;

    int checks   = 0;
    int failures = 0;

    mac_drain dut (
        .clk      (clk),
        .reset    (reset_n),
        .start    (start),
        .acc_in   (acc_in),
        .shift    (shift),
        .mac_clear(mac_clear),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Capture with ready held high, check every element, then idle.
    task automatic run_drain(input string tag, input logic [127:0] acc, input logic [4:0] sh,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        acc_in    = acc;
        shift     = sh;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_clear"}, 32'(mac_clear), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_index"}, 32'(out_index), 32'(i));
            chk({tag, "_data"},  32'(out_data),  32'(e[i]));
            chk({tag, "_last"},  32'(out_last),  32'(i == 3));
            tick();
        end
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        acc_in    = '0;
        shift     = '0;
        #3;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_clear", 32'(mac_clear), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic drain, with acc_in changed right after capture.
        acc_in    = pack4(32'd1000, 32'd40, 32'd7, 32'd1024);
        shift     = 5'd2;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start  = 1'b0;
        acc_in = pack4(32'd9, 32'd9, 32'd9, 32'd9);
        chk("basic_clear", 32'(mac_clear), 32'd1);
        chk("basic_busy",  32'(busy),      32'd1);
        chk("basic_d0",    32'(out_data),
`ifdef MAC_DRAIN_SIGNED_EN
            32'd127);
`else
            32'd250);
`endif
        tick();
        chk("basic_clear_off", 32'(mac_clear), 32'd0);
        chk("basic_d1",        32'(out_data),  32'd10);
        tick();
        chk("basic_d2",        32'(out_data),  32'd2);
        tick();
        chk("basic_d3",        32'(out_data),
`ifdef MAC_DRAIN_SIGNED_EN
            32'd127);
`else
            32'd255);
`endif
        chk("basic_last3",     32'(out_last),  32'd1);
        tick();
        chk("basic_done",      32'(busy),      32'd0);
        chk("basic_vld_off",   32'(out_valid), 32'd0);

        // Rounding at s=4 and passthrough / saturation at s=0.
        run_drain("round4", pack4(32'd40, 32'd23, 32'd24, 32'd0), 5'd4, 8'd3, 8'd1, 8'd2, 8'd0);
`ifdef MAC_DRAIN_SIGNED_EN
        run_drain("s0", pack4(32'd7, 32'd0, 32'd256, 32'd255), 5'd0, 8'd7, 8'd0, 8'd127, 8'd127);
        run_drain("sgn0", pack4(-32'sd300, 32'sd300, -32'sd5, 32'sd127), 5'd0,
                  8'h80, 8'd127, 8'hFB, 8'd127);
        run_drain("sgn1", pack4(-32'sd3, 32'sd3, -32'sd4, 32'h7FFFFFFF), 5'd1,
                  8'hFF, 8'd2, 8'hFE, 8'd127);
`else
        run_drain("s0", pack4(32'd7, 32'd0, 32'd256, 32'd255), 5'd0, 8'd7, 8'd0, 8'd255, 8'd255);
        run_drain("s31", pack4(32'hFFFFFFFF, 32'h80000000, 32'h40000000, 32'h3FFFFFFF), 5'd31,
                  8'd2, 8'd1, 8'd1, 8'd0);
`endif

        // Backpressure: ready pattern 0,0,1,0,1,1,1 gives handshakes 1..4.
        begin
            logic rdy [7];
            int   hs;
            rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            hs  = 0;
            acc_in    = pack4(32'd1, 32'd2, 32'd3, 32'd4);
            shift     = 5'd0;
            out_ready = 1'b0;
            start     = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < 7; k++) begin
                out_ready = rdy[k];
                tick();
                if (rdy[k]) hs++;
                if (hs == 4) begin
                    chk("bp_busy_fall", 32'(busy), 32'd0);
                end else begin
                    chk("bp_busy",  32'(busy),      32'd1);
                    chk("bp_index", 32'(out_index), 32'(hs));
                    chk("bp_data",  32'(out_data),  32'(hs + 1));
                end
            end
        end

        // start held through the stream and the final-handshake edge.
        acc_in    = pack4(32'd10, 32'd20, 32'd30, 32'd40);
        shift     = 5'd0;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        acc_in = pack4(32'd1, 32'd1, 32'd1, 32'd1);
        tick();
        chk("sb_clear1", 32'(mac_clear), 32'd0);
        chk("sb_d1",     32'(out_data),  32'd20);
        tick();
        chk("sb_d2",     32'(out_data),  32'd30);
        tick();
        chk("sb_d3",     32'(out_data),  32'd40);
        chk("sb_clear3", 32'(mac_clear), 32'd0);
        tick();
        chk("sb_final_busy",  32'(busy),      32'd0);
        chk("sb_final_clear", 32'(mac_clear), 32'd0);
        tick();
        start = 1'b0;
        chk("sb_restart_busy",  32'(busy),      32'd1);
        chk("sb_restart_clear", 32'(mac_clear), 32'd1);
        chk("sb_restart_data",  32'(out_data),  32'd1);
        chk("sb_restart_index", 32'(out_index), 32'd0);
        repeat (4) tick();
        chk("sb_restart_done",  32'(busy),      32'd0);

        // Reset mid-stream after two handshakes.
        acc_in    = pack4(32'd10, 32'd11, 32'd12, 32'd13);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mr_pre_index", 32'(out_index), 32'd2);
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_busy",  32'(busy),      32'd0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_index", 32'(out_index), 32'd0);
        chk("mr_data",  32'(out_data),  32'd0);
        chk("mr_clear", 32'(mac_clear), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_drain("post_rst", pack4(32'd20, 32'd21, 32'd22, 32'd23), 5'd0,
                  8'd20, 8'd21, 8'd22, 8'd23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
